data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Two-port arbiter that shares the single-ported byte-addressable data memory between the core load/store unit (master 0) and a DMA/debug master (master 1). One access is granted per cycle. The block muxes address, byte-enables and write data onto the memory port and registers the combinational read data. It returns a one-cycle-latency response to the granted master. Arbitration is fixed-priority with an anti-starvation counter and an optional master-1 burst lock.

Parameters:
- STARVE_MAX, 4: consecutive denied cycles of m1 before m1 is forced to win; range 1..15.
- LOCK_MAX, 8: maximum consecutive cycles m1 may hold the port via m1_lock_i; range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m0_req_i / m1_req_i  in  1  access request; held with payload until gnt
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read
- m0_be_i / m1_be_i  in  4  byte enables, bit i = byte addr+i
- m0_addr_i / m1_addr_i  in  13  byte address
- m0_wdata_i / m1_wdata_i  in  32  write data
- m1_lock_i  in  1  m1 requests to keep the port across consecutive accesses
- m0_gnt_o / m1_gnt_o  out  1  request accepted this cycle (combinational)
- m0_rvalid_o / m1_rvalid_o  out  1  response valid, one cycle after gnt
- m0_rdata_o / m1_rdata_o  out  32  response data
- mem_write_o  out  1  to memory write_i
- mem_be_o  out  4  to memory be_sel_i
- mem_addr_o  out  13  to memory addr_i
- mem_wdata_o  out  32  to memory data_i
- mem_rdata_i  in  32  from memory data_o (combinational read)

Behaviour:
- Clock is clk_i. Reset is synchronous and active-high on rst_i.
- While rst_i = 1, all gnt_o are forced to 0, so no memory access occurs.
- Reset values: rvalid_o = 0, rdata_o = 0, starve_cnt = 0, lock_cnt = 0, rr_ptr = 0, owner = NONE.
- Idle port: when no grant, mem_write_o = 0, mem_be_o = 0, and addr/wdata are driven 0.
- Granted port: mem_* equal the granted master's payload, with mem_write_o = we & gnt.
- Memory write takes effect at the clock edge ending the grant cycle.
- Reads: mem_rdata_i is sampled at the end of the grant cycle into resp_data.
- Response timing: the granted master's rvalid_o = 1 with rdata_o = resp_data in the following cycle.
- Write responses: rvalid_o also pulses for writes, with rdata_o = 0 (write ack).
- Non-granted master's rvalid_o = 0. rdata_o holds its last value when rvalid_o = 0.
- Throughput is one access per cycle; back-to-back grants to the same master are allowed.
- Grant FSM owner states:
  - NONE: default priority applies.
  - LOCK1: m1 holds the port.
- Default priority (owner NONE): m0 wins if m0_req_i; otherwise m1 wins if m1_req_i.
- Anti-starvation override: if starve_cnt == STARVE_MAX and m1_req_i, m1 wins even over m0.
- starve_cnt:
  - increments (saturating) each cycle m1_req_i = 1 and m1 is not granted.
  - clears to 0 on an m1 grant or when m1_req_i = 0.
- Lock transitions:
  - NONE -> LOCK1 when m1 is granted with m1_lock_i = 1; lock_cnt = 1.
  - In LOCK1, m1 wins whenever m1_req_i, m0 is denied, and lock_cnt increments on each m1 grant.
  - In LOCK1 with m1_req_i = 0 and m1_lock_i = 1, the port idles and m0 is still denied.
  - LOCK1 -> NONE when m1_lock_i = 0, or when lock_cnt reaches LOCK_MAX.
  - On the LOCK_MAX exit, m0 gets priority for at least the next cycle if it is requesting.
- be = 0 with req: the request is granted with no memory effect, and rvalid pulses with rdata = 0.
- Addresses near the top (addr > 8188): pass through unchanged; no wrap or error.
- Reset mid-operation: a grant issued in the cycle before rst_i still writes memory. Its rvalid is suppressed because rst_i clears the rvalid registers.

Optional Feature:
- Macro: DATA_MEM_ARB_RR_EN.
- Defined: default priority becomes round-robin. rr_ptr flips to the other master after each grant, and a contested cycle is won by the master indicated by rr_ptr. Starvation counter logic is removed (starve_cnt tied 0); lock behaviour is unchanged.
- Undefined: fixed priority plus anti-starvation counter, as above.

Decomposition:
- Shared package data_mem_pkg holds:
  - constants DMEM_AW = 13, DMEM_DW = 32, DMEM_BEW = 4;
  - owner state typedef/encoding (OWN_NONE = 0, OWN_LOCK1 = 1);
  - master index constants M0 = 0, M1 = 1.
- One natural sub-module, data_mem_arb_core: pure grant logic plus starve/lock/rr_ptr registers, producing gnt[1:0].
- The top level does payload muxing and response registers.

Test Plan:
- m0 write be=1111, addr=0x010, wdata=0xDEADBEEF, then m0 read addr=0x010 -> m0_gnt_o=1 same cycle; m0_rvalid_o next cycle with rdata 0, then 0xDEADBEEF.
- m0 and m1 both requesting reads every cycle, STARVE_MAX=4 -> m0 granted 4 cycles, m1 granted on the 5th, starve_cnt returns to 0.
- m1 lock_i=1 with 10 back-to-back reads, LOCK_MAX=8, m0 requesting throughout -> m1 granted 8 times, m0 granted in cycle 9, then default priority resumes.
- DATA_MEM_ARB_RR_EN defined, both masters requesting continuously -> grants alternate m0, m1, m0, m1 starting with m0 after reset.
- m1 write be=0110 addr=0x021 wdata=0x00AABB00, then read be=1111 addr=0x020 -> bytes 0x21,0x22 updated; read data = {old[0x23],0xAA,0xBB,old[0x20]}.
- rst_i asserted the cycle after an m0 read grant -> no rvalid_o pulse; gnt_o=0 during reset; first grant in the cycle after rst_i drops.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter: memory geometry, grant
// owner encoding, master indices and the response-word helper.
package data_mem_pkg;

  localparam int DMEM_AW  = 13;
  localparam int DMEM_DW  = 32;
  localparam int DMEM_BEW = 4;

  localparam int M0 = 0;
  localparam int M1 = 1;

  typedef enum logic {
    OWN_NONE  = 1'b0,
    OWN_LOCK1 = 1'b1
  } owner_e;

  // Writes and zero-byte-enable accesses answer with an all-zero word.
  function automatic logic [DMEM_DW-1:0] resp_word(
    input logic                we,
    input logic [DMEM_BEW-1:0] be,
    input logic [DMEM_DW-1:0]  rdata
  );
    logic [DMEM_DW-1:0] word;
    if (we || (be == 4'b0000)) begin
      word = 32'h0000_0000;
    end else begin
      word = rdata;
    end
    return word;
  endfunction

endpackage

// File: rtl/data_mem_arb_core.sv
// Grant decision for the two data memory masters. Holds the burst-lock owner
// state, the lock length counter and either the m1 anti-starvation counter
// (default build) or the round-robin pointer (DATA_MEM_ARB_RR_EN defined).
module data_mem_arb_core
  import data_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       m0_req_i,
  input  logic       m1_req_i,
  input  logic       m1_lock_i,
  output logic [1:0] gnt_o
);

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

  owner_e     owner_r;
  logic [3:0] lock_cnt_r;
  logic [1:0] gnt_s;
  logic       locked_s;
  logic       m1_pri_s;

`ifdef DATA_MEM_ARB_RR_EN
  logic rr_ptr_r;

  // A contested cycle goes to whichever master the pointer names.
  assign m1_pri_s = rr_ptr_r;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_r;

  // m1 overrides m0 only once it has been denied STARVE_MAX cycles in a row.
  assign m1_pri_s = (starve_cnt_r == STARVE_LIM);
`endif

  // Dropping m1_lock_i releases the port in the same cycle.
  assign locked_s = (owner_r == OWN_LOCK1) && m1_lock_i;

  // One-hot grant: reset blocks everything, a live lock favours m1 only.
  always_comb begin
    gnt_s = 2'b00;
    if (rst_i) begin
      gnt_s = 2'b00;
    end else if (locked_s) begin
      if (m1_req_i) begin
        gnt_s = 2'b10;
      end else begin
        gnt_s = 2'b00;
      end
    end else if (m0_req_i && m1_req_i) begin
      if (m1_pri_s) begin
        gnt_s = 2'b10;
      end else begin
        gnt_s = 2'b01;
      end
    end else if (m0_req_i) begin
      gnt_s = 2'b01;
    end else if (m1_req_i) begin
      gnt_s = 2'b10;
    end else begin
      gnt_s = 2'b00;
    end
  end

  assign gnt_o = gnt_s;

  // Arbitration history: fairness state plus lock owner and burst length.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_r    <= OWN_NONE;
      lock_cnt_r <= 4'd0;
`ifdef DATA_MEM_ARB_RR_EN
      rr_ptr_r   <= 1'b0;
`else
      starve_cnt_r <= 4'd0;
`endif
    end else begin
`ifdef DATA_MEM_ARB_RR_EN
      if (gnt_s[M0]) begin
        rr_ptr_r <= 1'b1;
      end else if (gnt_s[M1]) begin
        rr_ptr_r <= 1'b0;
      end
`else
      if (m1_req_i && !gnt_s[M1]) begin
        if (starve_cnt_r != STARVE_LIM) begin
          starve_cnt_r <= starve_cnt_r + 4'd1;
        end
      end else begin
        starve_cnt_r <= 4'd0;
      end
`endif
      case (owner_r)
        OWN_NONE: begin
          // A lock of length one ends with the grant that would start it.
          if (gnt_s[M1] && m1_lock_i && (LOCK_LIM != 4'd1)) begin
            owner_r    <= OWN_LOCK1;
            lock_cnt_r <= 4'd1;
          end else begin
            lock_cnt_r <= 4'd0;
          end
        end
        OWN_LOCK1: begin
          if (!m1_lock_i) begin
            owner_r    <= OWN_NONE;
            lock_cnt_r <= 4'd0;
          end else if (gnt_s[M1]) begin
            if ((lock_cnt_r + 4'd1) == LOCK_LIM) begin
              owner_r    <= OWN_NONE;
              lock_cnt_r <= 4'd0;
            end else begin
              lock_cnt_r <= lock_cnt_r + 4'd1;
            end
          end
        end
        default: begin
          owner_r    <= OWN_NONE;
          lock_cnt_r <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter in front of the single-ported data memory.
// Master 0 is the load/store unit, master 1 the DMA/debug port. Grants are
// combinational; each granted access is answered one cycle later with the
// registered read word (or zero for writes). Define DATA_MEM_ARB_RR_EN to
// replace fixed priority plus anti-starvation with round-robin.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [DMEM_BEW-1:0] m0_be_i,
  input  logic [DMEM_AW-1:0]  m0_addr_i,
  input  logic [DMEM_DW-1:0]  m0_wdata_i,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [DMEM_BEW-1:0] m1_be_i,
  input  logic [DMEM_AW-1:0]  m1_addr_i,
  input  logic [DMEM_DW-1:0]  m1_wdata_i,
  input  logic                m1_lock_i,
  output logic                m0_gnt_o,
  output logic                m1_gnt_o,
  output logic                m0_rvalid_o,
  output logic                m1_rvalid_o,
  output logic [DMEM_DW-1:0]  m0_rdata_o,
  output logic [DMEM_DW-1:0]  m1_rdata_o,
  output logic                mem_write_o,
  output logic [DMEM_BEW-1:0] mem_be_o,
  output logic [DMEM_AW-1:0]  mem_addr_o,
  output logic [DMEM_DW-1:0]  mem_wdata_o,
  input  logic [DMEM_DW-1:0]  mem_rdata_i
);

  logic [1:0]         gnt_s;
  logic [DMEM_DW-1:0] resp_data_s;
  logic               m0_rvalid_r;
  logic               m1_rvalid_r;
  logic [DMEM_DW-1:0] m0_rdata_r;
  logic [DMEM_DW-1:0] m1_rdata_r;

  data_mem_arb_core #(
    .STARVE_MAX (STARVE_MAX),
    .LOCK_MAX   (LOCK_MAX)
  ) u_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .m0_req_i  (m0_req_i),
    .m1_req_i  (m1_req_i),
    .m1_lock_i (m1_lock_i),
    .gnt_o     (gnt_s)
  );

  assign m0_gnt_o = gnt_s[M0];
  assign m1_gnt_o = gnt_s[M1];

  // Steer the granted payload onto the memory port; an idle port drives zeros.
  always_comb begin
    mem_write_o = 1'b0;
    mem_be_o    = 4'b0000;
    mem_addr_o  = 13'h0000;
    mem_wdata_o = 32'h0000_0000;
    if (gnt_s[M0]) begin
      mem_write_o = m0_we_i;
      mem_be_o    = m0_be_i;
      mem_addr_o  = m0_addr_i;
      mem_wdata_o = m0_wdata_i;
    end else if (gnt_s[M1]) begin
      mem_write_o = m1_we_i;
      mem_be_o    = m1_be_i;
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
    end else begin
      mem_write_o = 1'b0;
      mem_be_o    = 4'b0000;
      mem_addr_o  = 13'h0000;
      mem_wdata_o = 32'h0000_0000;
    end
  end

  assign resp_data_s = resp_word(mem_write_o, mem_be_o, mem_rdata_i);

  // Capture the response of this cycle's grant; data holds between responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m0_rvalid_r <= 1'b0;
      m1_rvalid_r <= 1'b0;
      m0_rdata_r  <= 32'h0000_0000;
      m1_rdata_r  <= 32'h0000_0000;
    end else begin
      m0_rvalid_r <= gnt_s[M0];
      m1_rvalid_r <= gnt_s[M1];
      if (gnt_s[M0]) begin
        m0_rdata_r <= resp_data_s;
      end
      if (gnt_s[M1]) begin
        m1_rdata_r <= resp_data_s;
      end
    end
  end

  // A response still in flight when reset arrives is never presented.
  assign m0_rvalid_o = m0_rvalid_r & ~rst_i;
  assign m1_rvalid_o = m1_rvalid_r & ~rst_i;
  assign m0_rdata_o  = m0_rdata_r;
  assign m1_rdata_o  = m1_rdata_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a word-organised byte-lane memory
// model. Stimulus pushes expected responses; a monitor pops them on rvalid.
module tb_data_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i, m1_lock_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [12:0] m0_addr_i, m1_addr_i;
  logic [31:0] m0_wdata_i, m1_wdata_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        mem_write_o;
  logic [3:0]  mem_be_o;
  logic [12:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        mon_en   = 1'b0;
  logic        mem_load = 1'b1;
  logic [31:0] mem_words [0:2047];

  always #5 clk_i = ~clk_i;

  data_mem_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .m0_req_i    (m0_req_i),
    .m0_we_i     (m0_we_i),
    .m0_be_i     (m0_be_i),
    .m0_addr_i   (m0_addr_i),
    .m0_wdata_i  (m0_wdata_i),
    .m1_req_i    (m1_req_i),
    .m1_we_i     (m1_we_i),
    .m1_be_i     (m1_be_i),
    .m1_addr_i   (m1_addr_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_lock_i   (m1_lock_i),
    .m0_gnt_o    (m0_gnt_o),
    .m1_gnt_o    (m1_gnt_o),
    .m0_rvalid_o (m0_rvalid_o),
    .m1_rvalid_o (m1_rvalid_o),
    .m0_rdata_o  (m0_rdata_o),
    .m1_rdata_o  (m1_rdata_o),
    .mem_write_o (mem_write_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Memory: byte n initialised to n[7:0]^8'h5A; lane i of a word = byte base+i.
  always @(posedge clk_i) begin
    if (mem_load) begin
      for (int w = 0; w < 2048; w++)
        for (int i = 0; i < 4; i++)
          mem_words[w][8*i +: 8] <= 8'(4*w + i) ^ 8'h5A;
    end else if (mem_write_o) begin
      for (int i = 0; i < 4; i++)
        if (mem_be_o[i]) mem_words[mem_addr_o[12:2]][8*i +: 8] <= mem_wdata_o[8*i +: 8];
    end
  end

  assign mem_rdata_i = mem_words[mem_addr_o[12:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Response monitor: every rvalid must match the oldest expected response.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (m0_rvalid_o) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL m0_rvalid: actual=unexpected pulse expected=none");
        end else chk("m0_rdata", m0_rdata_o, q0.pop_front());
      end
      if (m1_rvalid_o) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL m1_rvalid: actual=unexpected pulse expected=none");
        end else chk("m1_rdata", m1_rdata_o, q1.pop_front());
      end
    end
  end

  task automatic drive0(input logic req, input logic we, input logic [3:0] be,
                        input logic [12:0] addr, input logic [31:0] wd);
    m0_req_i = req; m0_we_i = we; m0_be_i = be; m0_addr_i = addr; m0_wdata_i = wd;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [3:0] be,
                        input logic [12:0] addr, input logic [31:0] wd, input logic lock);
    m1_req_i = req; m1_we_i = we; m1_be_i = be; m1_addr_i = addr; m1_wdata_i = wd;
    m1_lock_i = lock;
  endtask

  // One cycle: check grants and memory port, queue the expected responses.
  task automatic step(input string tag, input logic eg0, input logic eg1,
                      input logic [31:0] ed0, input logic [31:0] ed1);
    logic        xwe;
    logic [3:0]  xbe;
    logic [12:0] xad;
    logic [31:0] xwd;
    xwe = 1'b0; xbe = 4'b0000; xad = 13'h0000; xwd = 32'h0;
    if (eg0) begin
      xwe = m0_we_i; xbe = m0_be_i; xad = m0_addr_i; xwd = m0_wdata_i;
    end else if (eg1) begin
      xwe = m1_we_i; xbe = m1_be_i; xad = m1_addr_i; xwd = m1_wdata_i;
    end
    @(negedge clk_i);
    chk({tag, " gnt0"}, {31'b0, m0_gnt_o}, {31'b0, eg0});
    chk({tag, " gnt1"}, {31'b0, m1_gnt_o}, {31'b0, eg1});
    chk({tag, " mem_write"}, {31'b0, mem_write_o}, {31'b0, xwe});
    chk({tag, " mem_be"}, {28'b0, mem_be_o}, {28'b0, xbe});
    chk({tag, " mem_addr"}, {19'b0, mem_addr_o}, {19'b0, xad});
    chk({tag, " mem_wdata"}, mem_wdata_o, xwd);
    if (eg0) q0.push_back(ed0);
    if (eg1) q1.push_back(ed1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual=no finish expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    drive0(1'b1, 1'b0, 4'hF, 13'h0100, 32'h0);
    drive1(1'b1, 1'b0, 4'hF, 13'h0044, 32'h0, 1'b0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst gnt0", {31'b0, m0_gnt_o}, 32'h0);
    chk("rst gnt1", {31'b0, m1_gnt_o}, 32'h0);
    chk("rst rvalid0", {31'b0, m0_rvalid_o}, 32'h0);
    chk("rst rvalid1", {31'b0, m1_rvalid_o}, 32'h0);
    chk("rst rdata0", m0_rdata_o, 32'h0);
    chk("rst rdata1", m1_rdata_o, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; mem_load = 1'b0; mon_en = 1'b1;

    // Both masters contend with reads (m0 @0x100, m1 @0x044).
`ifdef DATA_MEM_ARB_RR_EN
    step("rr1", 1'b1, 1'b0, 32'h59585B5A, 32'h0);
    step("rr2", 1'b0, 1'b1, 32'h0, 32'h1D1C1F1E);
    step("rr3", 1'b1, 1'b0, 32'h59585B5A, 32'h0);
    step("rr4", 1'b0, 1'b1, 32'h0, 32'h1D1C1F1E);
`else
    for (int c = 0; c < 4; c++) step("stv_m0", 1'b1, 1'b0, 32'h59585B5A, 32'h0);
    step("stv_m1", 1'b0, 1'b1, 32'h0, 32'h1D1C1F1E);
    step("stv_after1", 1'b1, 1'b0, 32'h59585B5A, 32'h0);
    step("stv_after2", 1'b1, 1'b0, 32'h59585B5A, 32'h0);
`endif
    drive0(1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
    drive1(1'b0, 1'b0, 4'h0, 13'h0, 32'h0, 1'b0);
    step("idle", 1'b0, 1'b0, 32'h0, 32'h0);

    // m0 write then read back; a be=0 write must leave memory untouched.
    drive0(1'b1, 1'b1, 4'hF, 13'h0010, 32'hDEADBEEF);
    step("wr0", 1'b1, 1'b0, 32'h0, 32'h0);
    drive0(1'b1, 1'b0, 4'hF, 13'h0010, 32'h0);
    step("rd0", 1'b1, 1'b0, 32'hDEADBEEF, 32'h0);
    drive0(1'b1, 1'b1, 4'h0, 13'h0010, 32'hFFFFFFFF);
    step("be0_wr", 1'b1, 1'b0, 32'h0, 32'h0);
    drive0(1'b1, 1'b0, 4'hF, 13'h0010, 32'h0);
    step("be0_rd", 1'b1, 1'b0, 32'hDEADBEEF, 32'h0);
    drive0(1'b0, 1'b0, 4'h0, 13'h0, 32'h0);

    // m1 partial write into bytes 0x21/0x22, full-word read, top address.
    drive1(1'b1, 1'b1, 4'b0110, 13'h0021, 32'h00AABB00, 1'b0);
    step("wr1", 1'b0, 1'b1, 32'h0, 32'h0);
    drive1(1'b1, 1'b0, 4'hF, 13'h0020, 32'h0, 1'b0);
    step("rd1", 1'b0, 1'b1, 32'h0, 32'h79AABB7A);
    drive1(1'b1, 1'b0, 4'hF, 13'h1FFD, 32'h0, 1'b0);
    step("top", 1'b0, 1'b1, 32'h0, 32'hA5A4A7A6);

    // Lock held with no m1 request idles the port even though m0 asks.
    drive1(1'b1, 1'b0, 4'hF, 13'h0044, 32'h0, 1'b1);
    step("lk_take", 1'b0, 1'b1, 32'h0, 32'h1D1C1F1E);
    drive1(1'b0, 1'b0, 4'hF, 13'h0044, 32'h0, 1'b1);
    drive0(1'b1, 1'b0, 4'hF, 13'h0100, 32'h0);
    step("lk_idle", 1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 4'hF, 13'h0044, 32'h0, 1'b0);
    step("lk_rel", 1'b1, 1'b0, 32'h59585B5A, 32'h0);
    drive0(1'b0, 1'b0, 4'h0, 13'h0, 32'h0);

    // Burst lock capped at 8 grants with m0 waiting, then m0 wins.
    drive1(1'b1, 1'b0, 4'hF, 13'h0044, 32'h0, 1'b1);
    step("lm_1", 1'b0, 1'b1, 32'h0, 32'h1D1C1F1E);
    drive0(1'b1, 1'b0, 4'hF, 13'h0100, 32'h0);
    for (int c = 0; c < 7; c++) step("lm_hold", 1'b0, 1'b1, 32'h0, 32'h1D1C1F1E);
    step("lm_m0", 1'b1, 1'b0, 32'h59585B5A, 32'h0);
    drive0(1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
    m1_lock_i = 1'b0;
    step("lm_9", 1'b0, 1'b1, 32'h0, 32'h1D1C1F1E);
    step("lm_10", 1'b0, 1'b1, 32'h0, 32'h1D1C1F1E);
    drive1(1'b0, 1'b0, 4'h0, 13'h0, 32'h0, 1'b0);

    // Reset right after a write and a read grant.
    drive0(1'b1, 1'b1, 4'hF, 13'h0030, 32'h12345678);
    step("pre_rst_wr", 1'b1, 1'b0, 32'h0, 32'h0);
    drive0(1'b1, 1'b0, 4'hF, 13'h0030, 32'h0);
    @(negedge clk_i);
    chk("pre_rst_rd gnt0", {31'b0, m0_gnt_o}, 32'h1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("in_rst gnt0", {31'b0, m0_gnt_o}, 32'h0);
    chk("in_rst rvalid0", {31'b0, m0_rvalid_o}, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst gnt0", {31'b0, m0_gnt_o}, 32'h1);
    chk("post_rst rvalid0", {31'b0, m0_rvalid_o}, 32'h0);
    chk("post_rst rdata0", m0_rdata_o, 32'h0);
    q0.push_back(32'h12345678);
    @(posedge clk_i); #1;
    drive0(1'b0, 1'b0, 4'h0, 13'h0, 32'h0);

    repeat (3) step("drain", 1'b0, 1'b0, 32'h0, 32'h0);
    chk("q0 drained", q0.size(), 32'h0);
    chk("q1 drained", q1.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
